// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, word-addressed instruction memory and IF/ID register.
// Define IF_JUMP_FLUSH_EN to squash the wrong-path word on a taken jump.
module instruction_fetch #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_jump,
  input  logic [31:0] i_jump_addr,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_imem_wr_en,
  input  logic [31:0] i_imem_wr_addr,
  input  logic [31:0] i_imem_wr_data,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc4,
  output logic [31:0] o_pc
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;
  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic        unused_wr_addr_bits;

  // Byte addresses index whole words; out-of-range bits simply wrap.
  assign fetch_idx  = pc_reg[ADDR_W+1:2];
  assign wr_idx     = i_imem_wr_addr[ADDR_W+1:2];
  assign fetch_word = imem[fetch_idx];
  assign pc_plus4   = pc_reg + 32'd4;

  assign unused_wr_addr_bits = ^{i_imem_wr_addr[31:ADDR_W+2], i_imem_wr_addr[1:0]};

  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pc4_next   = pc4_reg;
    if (i_halt || i_stall) begin
      pc_next    = pc_reg;
      instr_next = instr_reg;
      pc4_next   = pc4_reg;
    end else if (i_jump) begin
      pc_next = i_jump_addr;
`ifdef IF_JUMP_FLUSH_EN
      instr_next = 32'h0000_0000;
      pc4_next   = 32'h0000_0000;
`else
      instr_next = fetch_word;
      pc4_next   = pc_plus4;
`endif
    end else begin
      pc_next    = pc_plus4;
      instr_next = fetch_word;
      pc4_next   = pc_plus4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_reg    <= 32'h0000_0000;
      instr_reg <= 32'h0000_0000;
      pc4_reg   <= 32'h0000_0000;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
    end
  end

  // Memory is never reset so a debug-loaded program survives a core reset.
  always_ff @(posedge i_clk) begin
    if (i_imem_wr_en) begin
      imem[wr_idx] <= i_imem_wr_data;
    end
  end

  assign o_instruction = instr_reg;
  assign o_pc4         = pc4_reg;
  assign o_pc          = pc_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (honours IF_JUMP_FLUSH_EN if defined).
module tb_instruction_fetch;

  logic        i_clk;
  logic        i_reset;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_stall;
  logic        i_halt;
  logic        i_imem_wr_en;
  logic [31:0] i_imem_wr_addr;
  logic [31:0] i_imem_wr_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc4;
  logic [31:0] o_pc;

  int checks = 0;
  int errors = 0;

`ifdef IF_JUMP_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  instruction_fetch #(.IMEM_DEPTH(256)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_stall        (i_stall),
    .i_halt         (i_halt),
    .i_imem_wr_en   (i_imem_wr_en),
    .i_imem_wr_addr (i_imem_wr_addr),
    .i_imem_wr_data (i_imem_wr_data),
    .o_instruction  (o_instruction),
    .o_pc4          (o_pc4),
    .o_pc           (o_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4);
    $display("step %-12s pc=%h instr=%h pc4=%h", tag, o_pc, o_instruction, o_pc4);
    chk({tag, ".pc"}, o_pc, e_pc);
    chk({tag, ".instr"}, o_instruction, e_instr);
    chk({tag, ".pc4"}, o_pc4, e_pc4);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    i_imem_wr_en   = 1'b1;
    i_imem_wr_addr = addr;
    i_imem_wr_data = data;
    tick();
    i_imem_wr_en   = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_jump = 1'b0; i_jump_addr = '0; i_stall = 1'b0; i_halt = 1'b0;
    i_imem_wr_en = 1'b0; i_imem_wr_addr = '0; i_imem_wr_data = '0;
    tick();
    chk3("reset", 32'h0, 32'h0, 32'h0);

    // Program load while held in reset
    wr(32'h000, 32'h11);   wr(32'h004, 32'h22);   wr(32'h008, 32'h33);
    wr(32'h00C, 32'h44);   wr(32'h010, 32'h55);   wr(32'h014, 32'h66);
    wr(32'h018, 32'h77);   wr(32'h040, 32'h1600); wr(32'h044, 32'h1700);
    wr(32'h048, 32'h1800); wr(32'h3FC, 32'hFF);
    chk3("reset_hold", 32'h0, 32'h0, 32'h0);

    i_reset = 1'b0;
    tick(); chk3("seq0", 32'h4, 32'h11, 32'h4);
    tick(); chk3("seq1", 32'h8, 32'h22, 32'h8);
    tick(); chk3("seq2", 32'hC, 32'h33, 32'hC);

    i_jump = 1'b1; i_jump_addr = 32'h8;
    tick(); chk3("jmp_8", 32'h8, FLUSH ? 32'h0 : 32'h44, FLUSH ? 32'h0 : 32'h10);
    i_jump_addr = 32'h40;
    tick(); chk3("jmp_40", 32'h40, FLUSH ? 32'h0 : 32'h33, FLUSH ? 32'h0 : 32'hC);
    i_jump = 1'b0;
    tick(); chk3("after_jmp", 32'h44, 32'h1600, 32'h44);

    // Stall overrides a pending jump
    i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h80;
    tick(); chk3("stall0", 32'h44, 32'h1600, 32'h44);
    tick(); chk3("stall1", 32'h44, 32'h1600, 32'h44);
    i_stall = 1'b0; i_jump = 1'b0;
    tick(); chk3("unstall", 32'h48, 32'h1700, 32'h48);

    // Halt freezes fetch while the debug port still writes memory
    i_halt = 1'b1; i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h0;
    wr(32'h010, 32'hDEADBEEF);
    chk3("halt0", 32'h48, 32'h1700, 32'h48);
    tick(); chk3("halt1", 32'h48, 32'h1700, 32'h48);
    i_halt = 1'b0; i_stall = 1'b0;
    i_jump_addr = 32'h10;
    tick(); chk3("jmp_10", 32'h10, FLUSH ? 32'h0 : 32'h1800, FLUSH ? 32'h0 : 32'h4C);
    i_jump = 1'b0;
    tick(); chk3("fetch_dead", 32'h14, 32'hDEADBEEF, 32'h14);

    // Same-edge write to the word being fetched: old word is latched
    wr(32'h014, 32'hCAFEF00D);
    chk3("wr_collide", 32'h18, 32'h66, 32'h18);
    i_jump = 1'b1; i_jump_addr = 32'h14;
    tick(); chk3("jmp_14", 32'h14, FLUSH ? 32'h0 : 32'h77, FLUSH ? 32'h0 : 32'h1C);
    i_jump = 1'b0;
    tick(); chk3("fetch_new", 32'h18, 32'hCAFEF00D, 32'h18);

    // Mid-run reset beats a jump; memory survives
    i_jump = 1'b1; i_jump_addr = 32'h20;
    tick(); chk3("jmp_20", 32'h20, FLUSH ? 32'h0 : 32'h77, FLUSH ? 32'h0 : 32'h1C);
    i_reset = 1'b1; i_jump_addr = 32'h40;
    tick(); chk3("reset_mid", 32'h0, 32'h0, 32'h0);
    i_reset = 1'b0; i_jump = 1'b0;
    tick(); chk3("post_reset", 32'h4, 32'h11, 32'h4);

    // Address wrap modulo IMEM_DEPTH
    i_jump = 1'b1; i_jump_addr = 32'h400;
    tick(); chk3("jmp_400", 32'h400, FLUSH ? 32'h0 : 32'h22, FLUSH ? 32'h0 : 32'h8);
    i_jump = 1'b0;
    tick(); chk3("wrap_fetch", 32'h404, 32'h11, 32'h404);

    // PC+4 wraps at 2^32
    i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
    tick(); chk3("jmp_top", 32'hFFFF_FFFC, FLUSH ? 32'h0 : 32'h22, FLUSH ? 32'h0 : 32'h408);
    i_jump = 1'b0;
    tick(); chk3("pc_wrap", 32'h0, 32'hFF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
